// File: rtl/param_priority_encoder_reg.sv
// rtl/param_priority_encoder_reg.sv - registered N-way priority/round-robin grant encoder
//
// Picks one of N request lines and presents it as a binary index plus a
// one-hot vector. The grant is held under a valid/ready handshake until
// the consumer accepts it.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-high reset
//   req          in   [N-1:0] request lines, bit i = requester i
//   out_ready    in   consumer accepts the presented grant this cycle
//   grant_valid  out  a grant is being presented
//   grant_idx    out  [IDX_W-1:0] binary index of the granted requester
//   grant_onehot out  [N-1:0] one-hot of grant_idx, zero when not valid
module param_priority_encoder_reg #(
    parameter  int N     = 4,
    parameter  int MODE  = 0,
    localparam int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             out_ready,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx,
    output logic [N-1:0]     grant_onehot
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(N - 1);

    state_t           state_q;
    logic [IDX_W-1:0] ptr_q;
    logic             grant_valid_q;
    logic [IDX_W-1:0] grant_idx_q;
    logic [N-1:0]     grant_onehot_q;

    logic             accept;
    logic [IDX_W-1:0] ptr_d;
    logic [IDX_W-1:0] search_start;
    logic             found;
    logic [IDX_W-1:0] win_idx_d;
    logic [N-1:0]     win_onehot_d;
    int               j;

    assign accept = (state_q == HOLD) && out_ready;

    // Pointer value after accepting the current grant: just below it, wrapping.
    assign ptr_d = (grant_idx_q == '0) ? TOP_IDX : grant_idx_q - 1'b1;

    // A winner chosen on the accept edge must already see the moved pointer.
    // Fixed priority is simply a search that always starts at the top index.
    always_comb begin
        search_start = ptr_q;
        if (MODE == 0) begin
            search_start = TOP_IDX;
        end else if (accept) begin
            search_start = ptr_d;
        end
    end

    // Descending circular search from search_start; first set bit wins.
    always_comb begin
        found     = 1'b0;
        win_idx_d = '0;
        j         = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(search_start) - k;
            if (j < 0) begin
                j = j + N;
            end
            if (!found && req[j[IDX_W-1:0]]) begin
                found     = 1'b1;
                win_idx_d = IDX_W'(j);
            end
        end
    end

    assign win_onehot_d = N'(1) << win_idx_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            ptr_q          <= TOP_IDX;
            grant_valid_q  <= 1'b0;
            grant_idx_q    <= '0;
            grant_onehot_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (found) begin
                        state_q        <= HOLD;
                        grant_valid_q  <= 1'b1;
                        grant_idx_q    <= win_idx_d;
                        grant_onehot_q <= win_onehot_d;
                    end
                end
                HOLD: begin
                    // Without an accept the grant stays frozen regardless of req.
                    if (out_ready) begin
                        ptr_q <= ptr_d;
                        if (found) begin
                            grant_idx_q    <= win_idx_d;
                            grant_onehot_q <= win_onehot_d;
                        end else begin
                            state_q        <= IDLE;
                            grant_valid_q  <= 1'b0;
                            grant_idx_q    <= '0;
                            grant_onehot_q <= '0;
                        end
                    end
                end
                default: begin
                    state_q        <= IDLE;
                    grant_valid_q  <= 1'b0;
                    grant_idx_q    <= '0;
                    grant_onehot_q <= '0;
                end
            endcase
        end
    end

    assign grant_valid  = grant_valid_q;
    assign grant_idx    = grant_idx_q;
    assign grant_onehot = grant_onehot_q;

endmodule

// File: tb/tb_param_priority_encoder_reg.sv
// tb/tb_param_priority_encoder_reg.sv - scoreboard bench for param_priority_encoder_reg
module tb_param_priority_encoder_reg;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Three instances: N=4 fixed, N=4 round-robin, N=5 round-robin.
    int nn[3] = '{4, 4, 5};
    int mm[3] = '{0, 1, 1};

    logic [7:0] reqv[3];
    logic       rdyv[3];
    logic       vld[3];
    logic [2:0] idx[3];
    logic [7:0] oh[3];

    logic [3:0] req0, req1;
    logic [4:0] req2;
    logic       gv0, gv1, gv2;
    logic [1:0] gi0, gi1;
    logic [2:0] gi2;
    logic [3:0] go0, go1;
    logic [4:0] go2;

    assign req0 = reqv[0][3:0];
    assign req1 = reqv[1][3:0];
    assign req2 = reqv[2][4:0];
    assign vld[0] = gv0;
    assign vld[1] = gv1;
    assign vld[2] = gv2;
    assign idx[0] = {1'b0, gi0};
    assign idx[1] = {1'b0, gi1};
    assign idx[2] = gi2;
    assign oh[0]  = {4'b0, go0};
    assign oh[1]  = {4'b0, go1};
    assign oh[2]  = {3'b0, go2};

    param_priority_encoder_reg #(.N(4), .MODE(0)) u_fix4 (
        .clk(clk), .rst(rst), .req(req0), .out_ready(rdyv[0]),
        .grant_valid(gv0), .grant_idx(gi0), .grant_onehot(go0));
    param_priority_encoder_reg #(.N(4), .MODE(1)) u_rr4 (
        .clk(clk), .rst(rst), .req(req1), .out_ready(rdyv[1]),
        .grant_valid(gv1), .grant_idx(gi1), .grant_onehot(go1));
    param_priority_encoder_reg #(.N(5), .MODE(1)) u_rr5 (
        .clk(clk), .rst(rst), .req(req2), .out_ready(rdyv[2]),
        .grant_valid(gv2), .grant_idx(gi2), .grant_onehot(go2));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int c, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut=%0d actual=%0d expected=%0d t=%0t", nm, c, act, exp, $time);
        end
    endtask

    // Reference model: per-instance holding flag, current grant, RR pointer.
    int unsigned exp_q[3][$];
    bit  m_hold[3];
    int  m_cur[3];
    int  m_ptr[3];
    bit  exp_valid[3];
    bit  mon_en = 1'b0;

    function automatic int winner(input logic [7:0] r, input int start, input int n);
        for (int k = 0; k < n; k++) begin
            int jj = (start - k + n) % n;
            if (r[jj]) return jj;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 3; c++) begin
            exp_q[c].delete();
            m_hold[c]    = 1'b0;
            m_cur[c]     = 0;
            m_ptr[c]     = nn[c] - 1;
            exp_valid[c] = 1'b0;
        end
    endtask

    // Predict the effect of the coming rising edge on instance c.
    task automatic model_step(input int c, input logic [7:0] r, input bit rd);
        int start;
        int w;
        if (!m_hold[c]) begin
            if (r != 0) begin
                start = (mm[c] == 1) ? m_ptr[c] : nn[c] - 1;
                w = winner(r, start, nn[c]);
                exp_q[c].push_back(w);
                m_hold[c] = 1'b1;
                m_cur[c]  = w;
            end
        end else if (rd) begin
            m_ptr[c] = (m_cur[c] == 0) ? nn[c] - 1 : m_cur[c] - 1;
            if (r != 0) begin
                start = (mm[c] == 1) ? m_ptr[c] : nn[c] - 1;
                w = winner(r, start, nn[c]);
                exp_q[c].push_back(w);
                m_cur[c] = w;
            end else begin
                m_hold[c] = 1'b0;
            end
        end
    endtask

    // Called at posedge+2; drives inputs for the next edge and returns at the next posedge+2.
    task automatic apply(input logic [7:0] r, input bit rd0, input bit rd1, input bit rd2);
        logic [7:0] rm;
        for (int c = 0; c < 3; c++) begin
            rm = r & 8'((1 << nn[c]) - 1);
            reqv[c] = rm;
            rdyv[c] = (c == 0) ? rd0 : ((c == 1) ? rd1 : rd2);
            exp_valid[c] = m_hold[c];
            model_step(c, rm, rdyv[c]);
        end
        @(posedge clk);
        #2;
    endtask

    // Monitor: checks the presented grant against the scoreboard head; pops on accept.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int c = 0; c < 3; c++) begin
                chk("valid", c, vld[c], exp_valid[c]);
                chk("onehot", c, oh[c], vld[c] ? (64'd1 << idx[c]) : 64'd0);
                if (vld[c]) begin
                    chk("idx_range", c, (int'(idx[c]) < nn[c]), 1);
                    if (exp_q[c].size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL scoreboard_empty dut=%0d actual_idx=%0d expected=none t=%0t", c, idx[c], $time);
                    end else begin
                        chk("grant_idx", c, idx[c], exp_q[c][0]);
                        if (rdyv[c]) void'(exp_q[c].pop_front());
                    end
                end
            end
        end
    end

    logic [7:0] dir_req[29] = '{
        8'b1111, 8'b1111, 8'b1111, 8'b1111, 8'b1111, 8'b1111,
        8'b0110, 8'b0001, 8'b0000, 8'b0000,
        8'b0110, 8'b1001, 8'b1001, 8'b1001, 8'b1001, 8'b1001, 8'b1001, 8'b0000,
        8'b0101, 8'b0101, 8'b0101, 8'b0101, 8'b0000, 8'b0000, 8'b0000, 8'b0101,
        8'b10011, 8'b10011, 8'b10011};
    bit dir_rdy[29] = '{
        1, 1, 1, 1, 1, 1,
        1, 1, 1, 1,
        1, 0, 0, 0, 0, 0, 1, 1,
        1, 1, 1, 1, 1, 1, 1, 1,
        1, 1, 1};

    initial begin
        for (int c = 0; c < 3; c++) begin
            reqv[c] = '0;
            rdyv[c] = 1'b0;
        end
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        for (int c = 0; c < 3; c++) begin
            chk("reset_valid", c, vld[c], 0);
            chk("reset_idx", c, idx[c], 0);
            chk("reset_onehot", c, oh[c], 0);
        end
        rst = 1'b0;
        mon_en = 1'b1;

        for (int s = 0; s < 29; s++) apply(dir_req[s], dir_rdy[s], dir_rdy[s], dir_rdy[s]);
        repeat (4) apply(8'h00, 1, 1, 1);

        repeat (1500) begin
            logic [7:0] r;
            r = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            apply(r, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0);
        end

        // Asynchronous reset while holding, between clock edges.
        apply(8'hff, 0, 0, 0);
        apply(8'hff, 0, 0, 0);
        #1;
        rst = 1'b1;
        mon_en = 1'b0;
        #1;
        for (int c = 0; c < 3; c++) begin
            chk("async_rst_valid", c, vld[c], 0);
            chk("async_rst_idx", c, idx[c], 0);
            chk("async_rst_onehot", c, oh[c], 0);
        end
        @(posedge clk);
        #2;
        model_reset();
        rst = 1'b0;
        mon_en = 1'b1;
        apply(8'hff, 0, 0, 0);
        for (int c = 0; c < 3; c++) begin
            chk("post_rst_valid", c, vld[c], 1);
            chk("post_rst_idx", c, idx[c], nn[c] - 1);
        end

        repeat (500) begin
            apply(8'($urandom), $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0);
        end

        repeat (4) apply(8'h00, 1, 1, 1);
        for (int c = 0; c < 3; c++) begin
            chk("drain_valid", c, vld[c], 0);
            chk("drain_queue", c, exp_q[c].size(), 0);
        end
        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
